// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: field widths, opcodes, ALUOp codes and the
// control-bundle structs carried through the ID/EX latch.
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ex;
    m_ctrl_t  m;
    wb_ctrl_t wb;
  } ctrl_t;
endpackage

// File: rtl/register_file.sv
// 32-entry register file: two async read ports, one sync write port,
// r0 hardwired to zero, write-first bypass so a same-cycle write is visible.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_d[i] = '0;
    end else if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) regs_q <= regs_d;

  // Bypass is gated by wr_en, so r0 never forwards a write.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (raddr1 == '0)                    rdata1 = '0;
    else if (wr_en && waddr == raddr1)   rdata1 = wdata;
    if (raddr2 == '0)                    rdata2 = '0;
    else if (wr_en && waddr == raddr2)   rdata2 = wdata;
  end
endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: control decode, register read, sign extend, and the ID/EX
// latch. Branch-taken flush zeroes only the control fields.
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_instr,
  input  logic [DATA_W-1:0]     id_npc,
  input  logic                  ex_mem_pc_src,
  input  logic                  mem_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_write_reg,
  input  logic [DATA_W-1:0]     mem_wb_write_data,
  output logic [1:0]            id_ex_wb,
  output logic [2:0]            id_ex_m,
  output logic [3:0]            id_ex_ex,
  output logic [DATA_W-1:0]     id_ex_npc,
  output logic [DATA_W-1:0]     id_ex_readdat1,
  output logic [DATA_W-1:0]     id_ex_readdat2,
  output logic [DATA_W-1:0]     id_ex_sign_ext,
  output logic [4:0]            id_ex_instr_2016,
  output logic [4:0]            id_ex_instr_1511
);
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] rdata1, rdata2, sext;
  ctrl_t             ctrl;

  ctrl_t             ctrl_d, ctrl_q;
  logic [DATA_W-1:0] npc_d, npc_q, rd1_d, rd1_q, rd2_d, rd2_q, sext_d, sext_q;
  logic [4:0]        rt_d, rt_q, rd_d, rd_q;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];
  assign sext   = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

  register_file #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (mem_wb_regwrite),
    .waddr  (mem_wb_write_reg),
    .wdata  (mem_wb_write_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Unrecognised opcodes decode to an all-zero bubble.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.ex = '{regdst: 1'b1, aluop: ALUOP_FUNCT, alusrc: 1'b0};
        ctrl.wb = '{regwrite: 1'b1, memtoreg: 1'b0};
      end
      OP_LW: begin
        ctrl.ex = '{regdst: 1'b0, aluop: ALUOP_ADD, alusrc: 1'b1};
        ctrl.m  = '{branch: 1'b0, memread: 1'b1, memwrite: 1'b0};
        ctrl.wb = '{regwrite: 1'b1, memtoreg: 1'b1};
      end
      OP_SW: begin
        ctrl.ex = '{regdst: 1'b0, aluop: ALUOP_ADD, alusrc: 1'b1};
        ctrl.m  = '{branch: 1'b0, memread: 1'b0, memwrite: 1'b1};
      end
      OP_BEQ: begin
        ctrl.ex = '{regdst: 1'b0, aluop: ALUOP_SUB, alusrc: 1'b0};
        ctrl.m  = '{branch: 1'b1, memread: 1'b0, memwrite: 1'b0};
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    ctrl_d = ex_mem_pc_src ? '0 : ctrl;
    npc_d  = id_npc;
    rd1_d  = rdata1;
    rd2_d  = rdata2;
    sext_d = sext;
    rt_d   = rt;
    rd_d   = rd;
    if (rst) begin
      ctrl_d = '0;
      npc_d  = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      sext_d = '0;
      rt_d   = '0;
      rd_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    npc_q  <= npc_d;
    rd1_q  <= rd1_d;
    rd2_q  <= rd2_d;
    sext_q <= sext_d;
    rt_q   <= rt_d;
    rd_q   <= rd_d;
  end

  assign id_ex_wb         = ctrl_q.wb;
  assign id_ex_m          = ctrl_q.m;
  assign id_ex_ex         = ctrl_q.ex;
  assign id_ex_npc        = npc_q;
  assign id_ex_readdat1   = rd1_q;
  assign id_ex_readdat2   = rd2_q;
  assign id_ex_sign_ext   = sext_q;
  assign id_ex_instr_2016 = rt_q;
  assign id_ex_instr_1511 = rd_q;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction-decode (ID) stage of the 5-stage MIPS pipeline. It consumes the instruction and next-PC produced by the fetch stage's IF/ID latch. It decodes control, reads the 32x32 register file and sign-extends the immediate, then registers everything into the ID/EX latch. It also accepts the MEM/WB write-back port and a branch-taken flush from EX/MEM.

Parameters:
DATA_W, 32, datapath/register width
REG_COUNT, 32, number of architectural registers (index width = 5)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
id_instr  input  32  instruction from IF/ID latch
id_npc  input  32  PC+4 from IF/ID latch
ex_mem_pc_src  input  1  branch taken; flushes the instruction being decoded
mem_wb_regwrite  input  1  write-back enable
mem_wb_write_reg  input  5  write-back destination register
mem_wb_write_data  input  32  write-back data
id_ex_wb  output  2  {RegWrite, MemtoReg}
id_ex_m  output  3  {Branch, MemRead, MemWrite}
id_ex_ex  output  4  {RegDst, ALUOp[1:0], ALUSrc}
id_ex_npc  output  32  registered id_npc
id_ex_readdat1  output  32  rs value
id_ex_readdat2  output  32  rt value
id_ex_sign_ext  output  32  sign-extended instr[15:0]
id_ex_instr_2016  output  5  rt field
id_ex_instr_1511  output  5  rd field

Behaviour:
- Reset (rst=1 at posedge): all id_ex_* outputs become 0; all registers r0..r31 become 0. Reset has priority over flush and write-back.
- Latency: fields decoded from id_instr during cycle N appear on id_ex_* after posedge N+1. There is exactly one register stage and no stalls.
- Control decode on opcode instr[31:26]. Values are listed as ex/m/wb:
  - 000000 R-type: 1100 / 000 / 10
  - 100011 lw: 0001 / 010 / 11
  - 101011 sw: 0001 / 001 / 00
  - 000100 beq: 0010 / 100 / 00
  - any other opcode: 0000 / 000 / 00 (bubble)
- Flush: if ex_mem_pc_src=1 at the posedge, id_ex_wb, id_ex_m and id_ex_ex load 0. Data fields (npc, readdat, sign_ext, rt, rd) load normally.
- Register file reads:
  - Asynchronous; rs = instr[25:21], rt = instr[20:16].
  - r0 always reads 0; writes to r0 are ignored.
- Register file writes: on posedge when mem_wb_regwrite=1 and mem_wb_write_reg!=0.
- Write-first bypass: if a write targets the register being read in the same cycle (nonzero index), the read returns mem_wb_write_data. The ID/EX latch therefore captures the new value.
- Sign extend: {{16{instr[15]}}, instr[15:0]}.
- Simultaneous write-back and flush: the write still occurs; only the control fields are zeroed.
- Reset mid-stream: the next cycle after rst deasserts, decode resumes from whatever id_instr presents. No residual state survives reset.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - ALUOp encodings
  - field widths DATA_W and REG_ADDR_W=5
- Sub-module register_file: 32x32 storage, two async read ports, one sync write port, r0 hardwired, write-first bypass.
- The control decoder is a combinational block inside decode_stage.

Test Plan:
1. Reset: rst=1 for 2 cycles with id_instr=0x8C220004 -> all id_ex_* =0; after release, reading r1/r2 returns 0.
2. Write then read: write r2=0x0000_00AA, then decode 0x00430820 (add r1,r2,r3), r3=0x11 -> id_ex_readdat1=0xAA, readdat2=0x11, ex=1100, wb=10, rd=1, one cycle later.
3. lw decode: id_instr=0x8C22FFFC, id_npc=0x8 -> ex=0001, m=010, wb=11, sign_ext=0xFFFFFFFC, instr_2016=2, npc=0x8.
4. Bypass: in the same cycle, mem_wb writes r5=0xDEADBEEF and id_instr=0x00A53020 -> readdat1=readdat2=0xDEADBEEF. Then attempt to write r0=0xFFFFFFFF -> subsequent read of r0 returns 0.
5. Flush: beq 0x1085FFFE decoded with ex_mem_pc_src=1 -> id_ex_m=000, id_ex_ex=0000, id_ex_wb=00, sign_ext=0xFFFFFFFE. Same instruction with pc_src=0 -> m=100, ex=0010.
6. Unknown opcode 0xFC000000 -> all control fields 0. Assert rst mid-stream after programming r7 -> r7 reads 0 and outputs clear on the same edge.
